// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display demultiplexer:
// FSM encoding, active-low segment patterns and anode helpers.
package display_pkg;

    typedef enum logic [1:0] {StBlank, StSettle, StHeld} state_t;

    localparam logic [3:0] AnodeBlank = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] Seg0 = 7'h40;
    localparam logic [6:0] Seg1 = 7'h79;
    localparam logic [6:0] Seg2 = 7'h24;
    localparam logic [6:0] Seg3 = 7'h30;
    localparam logic [6:0] Seg4 = 7'h19;
    localparam logic [6:0] Seg5 = 7'h12;
    localparam logic [6:0] Seg6 = 7'h02;
    localparam logic [6:0] Seg7 = 7'h78;
    localparam logic [6:0] Seg8 = 7'h00;
    localparam logic [6:0] Seg9 = 7'h10;
    localparam logic [6:0] SegA = 7'h08;
    localparam logic [6:0] SegB = 7'h03;
    localparam logic [6:0] SegC = 7'h46;
    localparam logic [6:0] SegD = 7'h21;
    localparam logic [6:0] SegE = 7'h06;
    localparam logic [6:0] SegF = 7'h0E;

    function automatic logic [2:0] low_count(input logic [3:0] an);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~an[i]};
        end
        return n;
    endfunction

    // Only meaningful when exactly one anode bit is low.
    function automatic logic [1:0] low_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational decode of an active-low 7-segment pattern to its hex nibble;
// anything outside the 16 standard glyphs is flagged illegal.
module decodificador_7seg
    import display_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       illegal
);

    always_comb begin
        nibble  = 4'h0;
        illegal = 1'b0;
        case (seg)
            Seg0:    nibble = 4'h0;
            Seg1:    nibble = 4'h1;
            Seg2:    nibble = 4'h2;
            Seg3:    nibble = 4'h3;
            Seg4:    nibble = 4'h4;
            Seg5:    nibble = 4'h5;
            Seg6:    nibble = 4'h6;
            Seg7:    nibble = 4'h7;
            Seg8:    nibble = 4'h8;
            Seg9:    nibble = 4'h9;
            SegA:    nibble = 4'hA;
            SegB:    nibble = 4'hB;
            SegC:    nibble = 4'hC;
            SegD:    nibble = 4'hD;
            SegE:    nibble = 4'hE;
            SegF:    nibble = 4'hF;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/display_demux.sv
// Recovers the four hex digits shown on a scanned active-low 7-segment display.
// Define DISPLAY_DEMUX_DP_EN to also capture the per-digit decimal point.
module display_demux
    import display_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic [3:0]  i_Anodo,
    input  logic [6:0]  i_Seg,
`ifdef DISPLAY_DEMUX_DP_EN
    input  logic        i_Dp,
    output logic [3:0]  o_Dp,
`endif
    output logic [15:0] o_Digitos,
    output logic [3:0]  o_Valido,
    output logic [1:0]  o_Sel,
    output logic        o_Frame,
    output logic        o_Err
);

`ifdef DISPLAY_DEMUX_DP_EN
    localparam int unsigned SampleW = 12;
`else
    localparam int unsigned SampleW = 11;
`endif

    localparam int unsigned     CntW    = 8;
    localparam logic [CntW-1:0] CntHit  = CntW'(STABLE_CYCLES - 2);
    localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES - 1);
    localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoSat  = TmoW'(TIMEOUT_CYCLES);

    logic [SampleW-1:0] sample_in, sample_q, prev_q;
    logic [3:0]         cur_anode;
    logic [6:0]         cur_seg;
    logic               changed, anode_blank, anode_legal;
    logic [1:0]         idx;
    logic [3:0]         nibble;
    logic               seg_illegal;

    state_t             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               decide, capture, reject, reject_seg;
    logic [TmoW-1:0]    tmo_q, tmo_d;

    logic [15:0]        digits_q, digits_d;
    logic [3:0]         valid_q, valid_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         exp_q, exp_d;
    logic               frame_q, frame_d;
    logic               err_q, err_d;

`ifdef DISPLAY_DEMUX_DP_EN
    assign sample_in = {i_Dp, i_Anodo, i_Seg};
`else
    assign sample_in = {i_Anodo, i_Seg};
`endif

    assign cur_anode   = sample_q[10:7];
    assign cur_seg     = sample_q[6:0];
    assign changed     = (sample_q != prev_q);
    assign anode_blank = (cur_anode == AnodeBlank);
    assign anode_legal = (low_count(cur_anode) == 3'd1);
    assign idx         = low_index(cur_anode);

    decodificador_7seg u_dec (
        .seg     (cur_seg),
        .nibble  (nibble),
        .illegal (seg_illegal)
    );

    // Reset loads the blank pattern so a dwell can never straddle reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            sample_q <= '1;
            prev_q   <= '1;
        end else begin
            sample_q <= sample_in;
            prev_q   <= sample_q;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= StBlank;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (changed) begin
            state_d = anode_blank ? StBlank : StSettle;
        end else if (decide) begin
            state_d = StHeld;
        end
    end

    // The dwell is judged on the edge that would bring the count to STABLE_CYCLES-1.
    always_comb begin
        decide     = (state_q == StSettle) && !changed && (cnt_q == CntHit);
        capture    = decide && anode_legal && !seg_illegal;
        reject_seg = decide && anode_legal && seg_illegal;
        reject     = decide && !(anode_legal && !seg_illegal);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (changed || anode_blank) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        sel_d    = sel_q;
        exp_d    = exp_q;
        frame_d  = 1'b0;
        err_d    = reject;
        tmo_d    = tmo_q;

        if (capture) begin
            digits_d[{idx, 2'b00} +: 4] = nibble;
            valid_d[idx]                = 1'b1;
            sel_d                       = idx;
            tmo_d                       = '0;
            if (idx == exp_q) begin
                if (idx == 2'd3) begin
                    frame_d = 1'b1;
                    exp_d   = 2'd0;
                end else begin
                    exp_d = exp_q + 2'd1;
                end
            end else begin
                exp_d = (idx == 2'd0) ? 2'd1 : 2'd0;
            end
        end else if (tmo_q >= TmoLast) begin
            valid_d = '0;
            exp_d   = 2'd0;
            tmo_d   = TmoSat;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end

        if (reject_seg) begin
            valid_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            cnt_q    <= '0;
            tmo_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            sel_q    <= '0;
            exp_q    <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            exp_q    <= exp_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

`ifdef DISPLAY_DEMUX_DP_EN
    logic [3:0] dp_q;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            dp_q <= '0;
        end else if (capture) begin
            dp_q[idx] <= sample_q[SampleW-1];
        end
    end

    assign o_Dp = dp_q;
`endif

    assign o_Digitos = digits_q;
    assign o_Valido  = valid_q;
    assign o_Sel     = sel_q;
    assign o_Frame   = frame_q;
    assign o_Err     = err_q;

endmodule

// File: tb/tb_display_demux.sv
// Bench for display_demux: directed scenarios plus random scanning, with a
// dwell-level reference model feeding a per-cycle scoreboard.
module tb_display_demux;

    localparam int S = 4;
    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  anodo;
    logic [6:0]  seg;
    logic [15:0] digitos;
    logic [3:0]  valido;
    logic [1:0]  sel;
    logic        frame;
    logic        err;
`ifdef DISPLAY_DEMUX_DP_EN
    logic        dp_in;
    logic [3:0]  dp_out;
`endif

    display_demux #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_Anodo   (anodo),
        .i_Seg     (seg),
`ifdef DISPLAY_DEMUX_DP_EN
        .i_Dp      (dp_in),
        .o_Dp      (dp_out),
`endif
        .o_Digitos (digitos),
        .o_Valido  (valido),
        .o_Sel     (sel),
        .o_Frame   (frame),
        .o_Err     (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  val;
        logic [1:0]  sel;
        logic        frame;
        logic        err;
    } snap_t;

    snap_t sb[$];

    int vectors     = 0;
    int miscompares = 0;
    int frames_seen = 0;
    int errs_seen   = 0;
    int cycle       = 0;

    // Active-high glyphs for 0..F, {g,f,e,d,c,b,a}
    logic [6:0] glyph_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    logic [3:0] m_an;
    logic [6:0] m_seg;
    int         m_run;
    int         m_dig [4];
    bit         m_val [4];
    int         m_sel;
    int         m_exp;
    int         m_idle;

    function automatic logic [6:0] seg_of(input int v);
        logic [6:0] h;
        h = glyph_hi[v];
        return ~h;
    endfunction

    function automatic int seg_to_hex(input logic [6:0] s);
        for (int v = 0; v < 16; v++) begin
            if (seg_of(v) == s) return v;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle, act, req);
        end
    endtask

    // Predicts the outputs after the coming edge, given what that edge samples.
    task automatic model_step(input logic r, input logic [3:0] an, input logic [6:0] sg);
        snap_t e;
        int    lows;
        int    pos;
        int    v;
        bit    got;
        e = '0;
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                m_dig[i] = 0;
                m_val[i] = 0;
            end
            m_sel  = 0;
            m_exp  = 0;
            m_idle = 0;
            m_an   = 4'hF;
            m_seg  = 7'h7F;
            m_run  = 0;
        end else begin
            got = 0;
            if (m_run == S) begin
                lows = 0;
                pos  = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!m_an[i]) begin
                        lows++;
                        pos = i;
                    end
                end
                if (lows >= 2) begin
                    e.err = 1'b1;
                end else if (lows == 1) begin
                    v = seg_to_hex(m_seg);
                    if (v < 0) begin
                        e.err      = 1'b1;
                        m_val[pos] = 0;
                    end else begin
                        got        = 1;
                        m_dig[pos] = v;
                        m_val[pos] = 1;
                        m_sel      = pos;
                        if (pos == m_exp) begin
                            if (pos == 3) begin
                                e.frame = 1'b1;
                                m_exp   = 0;
                            end else begin
                                m_exp++;
                            end
                        end else begin
                            m_exp = (pos == 0) ? 1 : 0;
                        end
                    end
                end
            end
            if (got) begin
                m_idle = 0;
            end else begin
                if (m_idle < T) m_idle++;
                if (m_idle == T) begin
                    for (int i = 0; i < 4; i++) m_val[i] = 0;
                    m_exp = 0;
                end
            end
            if (an == m_an && sg == m_seg) begin
                if (m_run <= S) m_run++;
            end else begin
                m_run = 1;
            end
            m_an  = an;
            m_seg = sg;
            e.dig = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
            e.val = {m_val[3], m_val[2], m_val[1], m_val[0]};
            e.sel = 2'(m_sel);
        end
        sb.push_back(e);
    endtask

    task automatic apply(input logic r, input logic [3:0] an, input logic [6:0] sg);
        @(negedge clk);
        rst_n = r;
        anodo = an;
        seg   = sg;
        model_step(r, an, sg);
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
        repeat (n) apply(1'b1, an, sg);
    endtask

    always @(posedge clk) begin : monitor
        snap_t e;
        #1;
        cycle++;
        if (frame === 1'b1) frames_seen++;
        if (err === 1'b1) errs_seen++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("cycle snapshot", {8'h00, digitos, valido, sel, frame, err}, {8'h00, e});
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin : stimulus
        int         f0;
        int         e0;
        int         r;
        int         pick;
        int         j;
        logic [3:0] an;
        logic [6:0] sg;

        rst_n = 1'b0;
        anodo = 4'hF;
        seg   = 7'h7F;
`ifdef DISPLAY_DEMUX_DP_EN
        dp_in = 1'b1;
`endif
        apply(1'b0, 4'hF, 7'h7F);
        apply(1'b0, 4'hF, 7'h7F);
        check("reset outputs", {digitos, valido, sel, frame, err}, 32'h0);

        // In-order scan 0,1,2,3
        f0 = frames_seen;
        for (int k = 0; k < 4; k++) hold(~(4'b0001 << k), seg_of(k), 8);
        check("scan digits", digitos, 16'h3210);
        check("scan valid", valido, 4'hF);
        check("scan sel", sel, 2'd3);
        check("scan frame count", frames_seen - f0, 1);

        // Two anodes low
        e0 = errs_seen;
        hold(4'b1100, seg_of(5), 10);
        check("illegal anode err count", errs_seen - e0, 1);
        check("illegal anode digits", digitos, 16'h3210);

        // Dwell one sample too short
        apply(1'b0, 4'hF, 7'h7F);
        hold(4'b1110, 7'b0000000, 3);
        hold(4'hF, 7'h7F, 6);
        check("short dwell valid0", valido[0], 1'b0);
        check("short dwell digits", digitos, 16'h0000);

        // Out-of-order scan 0,2,1,3
        f0 = frames_seen;
        hold(4'b1110, seg_of(4), 8);
        hold(4'b1011, seg_of(5), 8);
        hold(4'b1101, seg_of(6), 8);
        hold(4'b0111, seg_of(7), 8);
        check("out-of-order digits", digitos, 16'h7564);
        check("out-of-order valid", valido, 4'hF);
        check("out-of-order frame count", frames_seen - f0, 0);

        // Reset on the third stable sample, then S fresh samples needed
        hold(4'b1110, seg_of(9), 2);
        apply(1'b0, 4'b1110, seg_of(9));
        for (int i = 1; i <= 7; i++) begin
            apply(1'b1, 4'b1110, seg_of(9));
            if (i == 1) check("mid-dwell reset outputs", {digitos, valido, sel, frame, err}, 32'h0);
            check("post-reset capture timing", valido[0], (i >= S + 2));
        end
        check("post-reset digit", digitos, 16'h0009);

        // Timeout after T idle cycles
        hold(4'b1110, seg_of(0), 8);
        hold(4'hF, 7'h7F, 17);
        check("timeout not yet", valido, 4'h1);
        apply(1'b1, 4'hF, 7'h7F);
        check("timeout expired", valido, 4'h0);
        hold(4'hF, 7'h7F, 2);

        // Random scanning
        for (int d = 0; d < 400; d++) begin
            r = $urandom_range(0, 39);
            if (r == 0) begin
                apply(1'b0, 4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)));
            end else if (r == 1) begin
                hold(4'hF, 7'h7F, $urandom_range(20, 26));
            end else begin
                pick = $urandom_range(0, 15);
                if (pick < 11) begin
                    an = ~(4'b0001 << $urandom_range(0, 3));
                end else if (pick < 13) begin
                    an = 4'hF;
                end else if (pick < 15) begin
                    an = 4'($urandom_range(0, 15));
                    j  = $urandom_range(0, 3);
                    an[j]           = 1'b0;
                    an[(j + 1) % 4] = 1'b0;
                end else begin
                    an = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 9) < 8) sg = seg_of($urandom_range(0, 15));
                else sg = 7'($urandom_range(0, 127));
                hold(an, sg, $urandom_range(1, 9));
            end
        end

        hold(4'hF, 7'h7F, 3);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_demux.md
DISPLAY_DEMUX -- requirements
Module: display_demux

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples required before a capture (range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, idle cycles with no capture before all digits are invalidated.
REQ-003 SHALL have port i_Clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_Anodo  input  4  scanned anode lines, active-low one-hot; bit k low selects digit k.
REQ-006 SHALL have port i_Seg  input  7  segment lines {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port o_Digitos  output  16  captured hex values, digit k in bits [4k+3:4k].
REQ-008 SHALL have port o_Valido  output  4  per-digit valid flag.
REQ-009 SHALL have port o_Sel  output  2  index of the last captured digit.
REQ-010 SHALL have port o_Frame  output  1  one-cycle pulse on completion of an in-order 0,1,2,3 scan.
REQ-011 SHALL have port o_Err  output  1  one-cycle pulse on an illegal anode or segment pattern.

Function
REQ-012 SHALL register i_Anodo and i_Seg once on input; all decisions use the registered sample.
REQ-013 SHALL count consecutive cycles with identical registered {anode,seg}; the counter clears to 0 on any change.
REQ-014 SHALL capture when the count reaches STABLE_CYCLES-1, exactly once per dwell; no recapture until the sample changes.
REQ-015 SHALL, on capture, write the decoded nibble to digit k, set o_Valido[k], and set o_Sel=k on the next edge; input-to-output latency is STABLE_CYCLES+1 cycles.
REQ-016 SHALL decode the 16 standard active-low patterns 0-9,A,b,C,d,E,F; any other pattern is illegal.
REQ-017 SHALL treat anode 4'b1111 as blanking: no capture, no error, stability counter held at 0.
REQ-018 SHALL treat anode patterns with two or more low bits as illegal: no capture, one o_Err pulse per dwell.
REQ-019 SHALL, for an illegal segment pattern on a legal anode, pulse o_Err once per dwell, clear o_Valido[k], and leave the digit value unchanged.
REQ-020 SHALL track scan order with a 2-bit expected index: a capture at the expected index advances it; a capture of digit 0 sets it to 1; any other capture resets it to 0.
REQ-021 SHALL pulse o_Frame on the same edge that captures digit 3 when the expected index was 3, then reset the expected index to 0.
REQ-022 SHALL use a 3-state machine: BLANK (anode off or changed), SETTLE (counting), HELD (captured or rejected, waiting for change); any sample change returns the machine to SETTLE, or to BLANK for 4'b1111.
REQ-023 SHALL clear all o_Valido bits and reset the expected index when TIMEOUT_CYCLES cycles pass without a capture; the timeout counter saturates and clears on every capture.

Reset
REQ-024 SHALL, while i_Rst_n is low at a clock edge, drive o_Digitos=0, o_Valido=0, o_Sel=0, o_Frame=0, o_Err=0, clear all counters and the expected index, and enter BLANK.
REQ-025 SHALL abandon any in-progress dwell on reset; the first capture after release needs STABLE_CYCLES fresh identical samples.

Configuration
REQ-026 SHALL, with DISPLAY_DEMUX_DP_EN defined, add input i_Dp (1 bit, active-low decimal point) and output o_Dp (4 bits, per-digit captured DP); i_Dp is registered and included in the stability compare.
REQ-027 SHALL, without DISPLAY_DEMUX_DP_EN, omit both DP ports; the decimal point does not exist.

Structure
REQ-028 SHALL place the state encoding (BLANK, SETTLE, HELD), the 16 segment pattern constants and the blanking anode constant in shared package display_pkg.
REQ-029 SHALL implement the segment-to-nibble decode as combinational sub-module decodificador_7seg (outputs nibble and illegal flag).

Verification
REQ-030 SHALL check: scan anodes 1110,1101,1011,0111 with patterns 0,1,2,3, each held 8 cycles -> o_Digitos=16'h3210, o_Valido=4'hF, one o_Frame pulse.
REQ-031 SHALL check: anode 1110 with 7'b0000000 held 3 cycles, then changed (STABLE_CYCLES=4) -> no capture, o_Valido[0] stays 0.
REQ-032 SHALL check: anode 1100 held 10 cycles -> exactly one o_Err pulse, o_Digitos unchanged.
REQ-033 SHALL check: scan order 0,2,1,3 -> digits captured, no o_Frame pulse.
REQ-034 SHALL check: i_Rst_n low for one cycle mid-dwell at the 3rd stable sample -> all outputs 0; capture occurs STABLE_CYCLES+1 cycles after release.
REQ-035 SHALL check: TIMEOUT_CYCLES=20, capture digit 0, then hold 1111 for 20 cycles -> o_Valido returns to 0.
